// File: rtl/sdf_pipe_bank.sv
// WIDTH-channel copy of the SDF buffer/inverter/gate cone, followed by a STAGES-deep valid/ready pipeline.
// Latency is STAGES cycles. Bubbles collapse, and in_ready ripples combinationally from out_ready.
module sdf_pipe_bank #(
  parameter int WIDTH  = 4,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] d1,
  input  logic [WIDTH-1:0] d2,
  input  logic             en,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] q1,
  output logic [WIDTH-1:0] q2,
  output logic [WIDTH-1:0] q3,
  output logic [15:0]      xfer_count
);

  localparam int DW = 3 * WIDTH;

  logic [WIDTH-1:0] w_n3, w_n4, w_n5, w_n6, w_n7;
  logic [DW-1:0]    w_cone;

  logic             r_vld [STAGES];
  logic [DW-1:0]    r_dat [STAGES];
  logic [15:0]      r_xfer;

  logic [STAGES-1:0] w_load;
  logic              w_prev_vld [STAGES];
  logic [DW-1:0]     w_prev_dat [STAGES];

  assign w_n3   = ~d1;
  assign w_n4   = d1 & d2;
  assign w_n5   = w_n3 | w_n4;
  assign w_n6   = ~(w_n5 & {WIDTH{en}});
  assign w_n7   = ~(w_n3 | w_n6);
  assign w_cone = {w_n7, w_n6, w_n5};

  // A stage loads when it is empty, or when its contents leave in the same cycle.
  // Walking from the output back toward the input lets one empty stage absorb a stall.
  always_comb begin
    logic w_rdy;
    w_load = '0;
    w_rdy  = out_ready;
    for (int k = STAGES - 1; k >= 0; k--) begin
      w_load[k] = ~r_vld[k] | w_rdy;
      w_rdy     = w_load[k];
    end
  end

  always_comb begin
    w_prev_vld[0] = in_valid;
    w_prev_dat[0] = w_cone;
    for (int k = 1; k < STAGES; k++) begin
      w_prev_vld[k] = r_vld[k-1];
      w_prev_dat[k] = r_dat[k-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < STAGES; k++) begin
        r_vld[k] <= 1'b0;
        r_dat[k] <= '0;
      end
      r_xfer <= 16'd0;
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (w_load[k]) begin
          r_vld[k] <= w_prev_vld[k];
          r_dat[k] <= w_prev_dat[k];
        end
      end
      if (r_vld[STAGES-1] && out_ready) r_xfer <= r_xfer + 16'd1;
    end
  end

  assign in_ready   = w_load[0];
  assign out_valid  = r_vld[STAGES-1];
  assign q1         = r_dat[STAGES-1][WIDTH-1:0];
  assign q2         = r_dat[STAGES-1][2*WIDTH-1:WIDTH];
  assign q3         = r_dat[STAGES-1][3*WIDTH-1:2*WIDTH];
  assign xfer_count = r_xfer;

endmodule

// File: tb/tb_sdf_pipe_bank.sv
// Directed bench for sdf_pipe_bank at WIDTH=4, STAGES=2.
module tb_sdf_pipe_bank;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] d1;
  logic [3:0] d2;
  logic       en;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] q1;
  logic [3:0] q2;
  logic [3:0] q3;
  logic [15:0] xfer_count;

  int checks = 0;
  int errors = 0;

  sdf_pipe_bank #(.WIDTH(4), .STAGES(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .d1         (d1),
    .d2         (d2),
    .en         (en),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .q1         (q1),
    .q2         (q2),
    .q3         (q3),
    .xfer_count (xfer_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_q(input string tag, input logic [3:0] e1, input logic [3:0] e2, input logic [3:0] e3);
    chk({tag, "_vld"}, {31'd0, out_valid}, 32'd1);
    chk({tag, "_q"}, {20'd0, q3, q2, q1}, {20'd0, e3, e2, e1});
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; d1 = 4'h0; d2 = 4'h0; en = 1'b0; out_ready = 1'b0;
    tick();
    tick();
    #1;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    rst = 1'b0;
    #1;
    chk("rst_vld", {31'd0, out_valid}, 32'd0);
    chk("rst_q", {20'd0, q3, q2, q1}, 32'd0);
    chk("rst_cnt", {16'd0, xfer_count}, 32'd0);
    chk("rst_nox", {31'd0, $isunknown({in_ready, out_valid, q1, q2, q3, xfer_count})}, 32'd0);

    // Gated-on beat
    d1 = 4'b1100; d2 = 4'b1010; en = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    chk("on_in_ready", {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    chk("on_lat1", {31'd0, out_valid}, 32'd0);
    tick();
    chk_q("on", 4'b1011, 4'b0100, 4'b1000);
    chk("on_cnt0", {16'd0, xfer_count}, 32'd0);
    tick();
    chk("on_cnt1", {16'd0, xfer_count}, 32'd1);
    chk("on_drained", {31'd0, out_valid}, 32'd0);

    // Gated-off beat; en changes after acceptance must not matter
    en = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0; en = 1'b1;
    tick();
    chk_q("off", 4'b1011, 4'b1111, 4'b0000);
    tick();
    chk("off_cnt", {16'd0, xfer_count}, 32'd2);

    // Stall with collapse: B1, B2, B3
    out_ready = 1'b0;
    in_valid = 1'b1; d1 = 4'b1111; d2 = 4'b0000; en = 1'b1;
    tick();
    d1 = 4'b0101; d2 = 4'b0011;
    #1;
    chk("st_rdy_b2", {31'd0, in_ready}, 32'd1);
    tick();
    d1 = 4'b1111; d2 = 4'b1111;
    #1;
    chk("st_full_rdy", {31'd0, in_ready}, 32'd0);
    chk_q("st_hold1", 4'b0000, 4'b1111, 4'b0000);
    tick();
    chk("st_full_rdy2", {31'd0, in_ready}, 32'd0);
    chk_q("st_hold2", 4'b0000, 4'b1111, 4'b0000);
    out_ready = 1'b1;
    #1;
    chk("st_ripple_rdy", {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    chk_q("st_b2", 4'b1011, 4'b0100, 4'b0001);
    chk("st_cnt3", {16'd0, xfer_count}, 32'd3);
    tick();
    chk_q("st_b3", 4'b1111, 4'b0000, 4'b1111);
    tick();
    chk("st_cnt5", {16'd0, xfer_count}, 32'd5);
    chk("st_empty", {31'd0, out_valid}, 32'd0);

    // Reset mid-flight, with out_ready high at the reset edge
    out_ready = 1'b0; in_valid = 1'b1; d1 = 4'b1111; d2 = 4'b0000;
    tick();
    tick();
    chk("mf_full_vld", {31'd0, out_valid}, 32'd1);
    in_valid = 1'b0; rst = 1'b1; out_ready = 1'b1;
    tick();
    rst = 1'b0;
    chk("mf_vld", {31'd0, out_valid}, 32'd0);
    chk("mf_cnt", {16'd0, xfer_count}, 32'd0);
    tick();
    chk("mf_stay_empty", {31'd0, out_valid}, 32'd0);
    d1 = 4'b1100; d2 = 4'b1010; en = 1'b1; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("mf_lat1", {31'd0, out_valid}, 32'd0);
    tick();
    chk_q("mf_beat", 4'b1011, 4'b0100, 4'b1000);
    tick();
    chk("mf_cnt1", {16'd0, xfer_count}, 32'd1);

    // Counter wrap under continuous streaming
    in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 65536; i++) tick();
    chk("wrap_ffff", {16'd0, xfer_count}, 32'h0000FFFF);
    chk("wrap_stream_vld", {31'd0, out_valid}, 32'd1);
    tick();
    chk("wrap_zero", {16'd0, xfer_count}, 32'd0);
    in_valid = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
